// File: rtl/param_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// param_mem_ctrl : single-port word memory, valid/ready access, zeroing sweep
// Rev 1.0
// ----------------------------------------------------------------------------
module param_mem_ctrl #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    inout  wire  [DATA_W-1:0] data,
    input  logic              clr_start,
    output logic              busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_addr;
    logic              rsp_rd;
    logic              accept;
    logic              clr_accept;
    logic              in_range;
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    assign in_range   = ({1'b0, req_addr} < (ADDR_W+1)'(DEPTH));
    assign req_ready  = rst_n && (state == IDLE) && !clr_start && (!rsp_valid || rsp_ready);
    assign accept     = req_valid && req_ready;
    assign clr_accept = (state == IDLE) && clr_start && !rsp_valid;
    assign busy       = (state == CLEAR);

    // Only successful reads own the shared bus; writes and errors leave it floating.
    assign data = (rst_n && rsp_valid && rsp_rd && !rsp_err) ? rsp_rdata : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            clr_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_rd    <= 1'b0;
        end else begin
            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_rd    <= !req_we;
                rsp_err   <= !in_range;
                if (!in_range) begin
                    rsp_rdata <= '0;
                end else if (req_we) begin
                    rsp_rdata <= req_wdata;
                end else begin
                    rsp_rdata <= mem[req_addr];
                end
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (clr_accept) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                    end
                end
                default: begin
                    if (clr_addr == LAST_ADDR) begin
                        state    <= IDLE;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
            endcase
        end
    end

    // Storage has no reset; a reset during the sweep simply stops further zeroing.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[clr_addr] <= '0;
            end else if (accept && req_we && in_range) begin
                mem[req_addr] <= req_wdata;
            end
        end
    end

endmodule
`default_nettype wire
